// File: rtl/cl_conveyer_pkg.sv
// Shared types and constants for the conveyer sink: source priority tag,
// output FIFO depth and statistics counter width.
package cl_conveyer_pkg;

  typedef enum logic {
    PRI_LO = 1'b0,
    PRI_HI = 1'b1
  } conveyer_pri_e;

  localparam int CL_CONVEYER_SINK_DEPTH = 2;
  localparam int CL_STAT_W              = 32;

endpackage

// File: rtl/cl_conveyer_sink_fifo.sv
// Two-entry output FIFO for the conveyer sink. The head entry drives the
// output directly, so out_data/out_user/out_valid all come from flops.
module cl_conveyer_sink_fifo
  import cl_conveyer_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic push,
  input  T     push_data,
  input  logic push_user,
  output logic space,
  output T     out_data,
  output logic out_user,
  output logic out_valid,
  input  logic out_ready
);

  localparam int CNT_W = $clog2(CL_CONVEYER_SINK_DEPTH + 1);

  typedef struct packed {
    T     data;
    logic user;
  } entry_t;

  entry_t             head;
  entry_t             tail;
  entry_t             push_entry;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               pop;

  assign pop        = out_valid & out_ready;
  assign push_entry = '{data: push_data, user: push_user};

  // A full FIFO still has room when the head leaves in the same cycle.
  assign space = (count < CNT_W'(CL_CONVEYER_SINK_DEPTH)) |
                 ((count == CNT_W'(CL_CONVEYER_SINK_DEPTH)) & pop);

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: both entries are reset because the head entry is the visible output,
  // which must read zero after reset; the storage is only two words.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      count     <= '0;
      out_valid <= 1'b0;
      head      <= '0;
      tail      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      count     <= count_next;
      out_valid <= (count_next != '0);
      case (count)
        CNT_W'(0): begin
          if (push) head <= push_entry;
        end
        CNT_W'(1): begin
          if (push && pop) head <= push_entry;
          else if (push)   tail <= push_entry;
        end
        default: begin
          if (pop)  head <= tail;
          if (push) tail <= push_entry;
        end
      endcase
    end
  end

  assign out_data = head.data;
  assign out_user = head.user;

endmodule

// File: rtl/cl_conveyer_sink.sv
// Conveyer chain terminal: merges hi/lo priority streams into one AXI-Stream
// with bounded hi bursts. Optional counters under CL_CONVEYER_SINK_STATS_EN.
module cl_conveyer_sink
  import cl_conveyer_pkg::*;
#(
  parameter type T            = logic [7:0],
  parameter int  MAX_HI_BURST = 4
) (
  input  logic clock_i,
  input  logic reset_i,
  input  T     in_hi_pri_tdata,
  input  logic in_hi_pri_tvalid,
  output logic in_hi_pri_tready,
  input  T     in_lo_pri_tdata,
  input  logic in_lo_pri_tvalid,
  output logic in_lo_pri_tready,
  output T     out_tdata,
  output logic out_tuser,
  output logic out_tvalid,
  input  logic out_tready
`ifdef CL_CONVEYER_SINK_STATS_EN
  ,
  output logic [CL_STAT_W-1:0] hi_count_o,
  output logic [CL_STAT_W-1:0] lo_count_o,
  output logic [CL_STAT_W-1:0] stall_count_o
`endif
);

  localparam int BC_W = (MAX_HI_BURST > 0) ? $clog2(MAX_HI_BURST + 1) : 1;
  localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_HI_BURST);

  logic            space;
  logic            grant_hi;
  logic            grant_lo;
  logic            lo_turn;
  logic            hi_hs;
  logic            lo_hs;
  logic            push;
  T                push_data;
  conveyer_pri_e   src;
  logic [BC_W-1:0] bc;

  // Low wins a contested cycle only once high has used up its burst allowance.
  assign lo_turn  = (MAX_HI_BURST != 0) && (bc == BC_MAX);
  assign grant_hi = in_hi_pri_tvalid & ~(in_lo_pri_tvalid & lo_turn);
  assign grant_lo = in_lo_pri_tvalid & ~grant_hi;

  // Readies are held low during reset so nothing is accepted in that cycle.
  assign in_hi_pri_tready = reset_i & space & grant_hi;
  assign in_lo_pri_tready = reset_i & space & grant_lo;

  assign hi_hs     = in_hi_pri_tvalid & in_hi_pri_tready;
  assign lo_hs     = in_lo_pri_tvalid & in_lo_pri_tready;
  assign push      = hi_hs | lo_hs;
  assign src       = grant_hi ? PRI_HI : PRI_LO;
  assign push_data = grant_hi ? in_hi_pri_tdata : in_lo_pri_tdata;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      bc <= '0;
    end else if (lo_hs || !in_lo_pri_tvalid) begin
      bc <= '0;
    end else if (hi_hs && (bc != BC_MAX)) begin
      bc <= bc + 1'b1;
    end
  end

  cl_conveyer_sink_fifo #(
    .T (T)
  ) u_fifo (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .push      (push),
    .push_data (push_data),
    .push_user (logic'(src)),
    .space     (space),
    .out_data  (out_tdata),
    .out_user  (out_tuser),
    .out_valid (out_tvalid),
    .out_ready (out_tready)
  );

`ifdef CL_CONVEYER_SINK_STATS_EN
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      hi_count_o    <= '0;
      lo_count_o    <= '0;
      stall_count_o <= '0;
    end else begin
      if (hi_hs)                     hi_count_o    <= hi_count_o + 1'b1;
      if (lo_hs)                     lo_count_o    <= lo_count_o + 1'b1;
      if (out_tvalid && !out_tready) stall_count_o <= stall_count_o + 1'b1;
    end
  end
`endif

endmodule

// File: doc/cl_conveyer_sink.md
Name: cl_conveyer_sink

Overview:
- Terminal receiver at the far end of a conveyer chain.
- Accepts the high- and low-priority output streams of the last conveyer stage and merges them into one AXI-Stream toward the result writer.
- Merge uses priority arbitration with a bounded high-priority burst, so low-priority items are never starved.
- A 2-entry output FIFO registers `out_tvalid` and `out_tdata` and keeps input readies independent of `out_tready`.

Parameters:
- T, logic[7:0], payload type carried on both conveyer streams.
- MAX_HI_BURST, 4, maximum consecutive high-priority grants while low is waiting; 0 = strict priority (no anti-starvation).

Ports:
- clock_i  input  1  single clock.
- reset_i  input  1  synchronous, active-low reset.
- in_hi_pri_tdata  input  $bits(T)  high-priority payload.
- in_hi_pri_tvalid  input  1  high-priority valid.
- in_hi_pri_tready  output  1  high-priority ready.
- in_lo_pri_tdata  input  $bits(T)  low-priority payload.
- in_lo_pri_tvalid  input  1  low-priority valid.
- in_lo_pri_tready  output  1  low-priority ready.
- out_tdata  output  $bits(T)  merged payload.
- out_tuser  output  1  source of item: 1 = high, 0 = low.
- out_tvalid  output  1  merged valid.
- out_tready  input  1  merged ready.

Behaviour:
- Reset (reset_i = 0 at a rising edge):
  - FIFO count = 0; out_tvalid = 0; out_tdata = 0; out_tuser = 0.
  - Burst counter bc = 0; both in_*_tready = 0 while reset is held.
  - Reset mid-operation discards buffered items; no partial transfer completes in that cycle.
- FIFO:
  - 2 entries of {T, tuser}; space = (count < 2) or (count = 2 and out_tvalid and out_tready).
  - Pop on out_tvalid & out_tready; push on any input handshake.
  - Simultaneous push and pop is legal at every count.
  - out_tvalid = (count != 0), driven from registers.
- Latency: an item accepted in cycle N appears on out_* in cycle N+1 if the FIFO was empty; order is preserved.
- Arbitration (combinational, one grant per cycle):
  - hi only valid -> grant hi.
  - lo only valid -> grant lo.
  - both valid -> grant lo iff MAX_HI_BURST != 0 and bc = MAX_HI_BURST; otherwise grant hi.
- Ready generation:
  - in_x_tready = space & grant_x; the non-granted input sees tready = 0.
  - tready may depend on tvalid; tvalid never depends on tready.
- Burst counter (width $clog2(MAX_HI_BURST+1)):
  - hi handshake while in_lo_pri_tvalid = 1 -> bc + 1, saturating at MAX_HI_BURST.
  - lo handshake -> 0.
  - in_lo_pri_tvalid = 0 -> 0.
  - otherwise hold.
- Back-pressure: with out_tready = 0, two items are accepted, then both readies drop; inputs must hold tvalid/tdata (AXI rule).
- No internal state machine beyond FIFO count and bc.

Optional Feature:
- Macro: CL_CONVEYER_SINK_STATS_EN.
- Defined:
  - Adds outputs hi_count_o [31:0] and lo_count_o [31:0], registered, reset to 0.
  - Each increments on its input handshake and wraps 0xFFFFFFFF -> 0.
  - Adds stall_count_o [31:0], incremented each cycle out_tvalid = 1 and out_tready = 0, wrapping.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package cl_conveyer_pkg holds:
  - typedef conveyer_pri_e {PRI_LO = 0, PRI_HI = 1}, used for out_tuser.
  - localparam CL_CONVEYER_SINK_DEPTH = 2.
  - localparam CL_STAT_W = 32.
- One natural sub-module: cl_conveyer_sink_fifo, a 2-entry registered FIFO parameterised on type T.

Test Plan:
- Reset then hi-only burst: 8 hi items 0x10..0x17, out_tready = 1 -> out 0x10..0x17, tuser = 1, each 1 cycle after accept, lo tready = 0 throughout.
- Both streams always valid, MAX_HI_BURST = 4, hi 0xA0.., lo 0x50.. -> output tuser pattern 1,1,1,1,0 repeating; bc returns to 0 after each lo.
- MAX_HI_BURST = 0, both valid for 10 cycles -> 10 hi items out, zero lo accepted.
- out_tready = 0 for 5 cycles with hi valid -> exactly 2 accepted, in_hi_pri_tready = 0 from cycle 3. Release -> items emerge in order with no loss or duplication.
- Reset asserted low with 2 items buffered -> next cycle out_tvalid = 0, count = 0. Release -> fresh item passes with latency 1.
- With CL_CONVEYER_SINK_STATS_EN and 6 hi + 3 lo transfers plus 4 stall cycles -> hi_count_o = 6, lo_count_o = 3, stall_count_o = 4.
